serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 35 +++
 rtl/bit_timer.sv | 52 +++++
 rtl/serial_tx.sv | 164 ++++++++++++++++
 tb/tb_serial_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
//
// Types and constants shared by both ends of the single-wire serial link:
// the transmitter (serial_tx) and the receiving sequence detector.
//
// Contents:
//   tx_state_t   - frame FSM states (IDLE, START, DATA, STOP)
//   IDLE_LVL     - line level while no frame is in flight
//   START_LVL    - line level of the start bit
//   STOP_LVL     - line level of the stop bit
//   clog2_min1() - counter width helper that never returns 0
// -----------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // The start bit is the only high framing level, so a receiver idling
  // on a low line sees the rising edge that marks the beginning of a frame.
  localparam logic IDLE_LVL  = 1'b0;
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;

  // Counter width for a value range 0..n-1. A 1-entry range still needs a
  // 1-bit register so that vector declarations stay legal.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
//
// Free-running bit-period counter. Counts 0..BIT_CYCLES-1 while enabled and
// wraps; tick is high in the cycle the counter sits on its terminal count,
// so the owner advances exactly once per bit period.
//
// Parameters:
//   BIT_CYCLES - clock cycles per bit period (>= 1)
//
// Ports:
//   clk   in  clock, rising edge
//   reset in  synchronous active-high reset, clears the count
//   clear in  synchronous clear, wins over en
//   en    in  count enable
//   tick  out terminal count reached this cycle (only while en and not clear)
// -----------------------------------------------------------------------------
module bit_timer
  import serial_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int TW = clog2_min1(BIT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + TW'(1);
      end
    end
  end

  // With BIT_CYCLES=1 the count is pinned at 0 and tick simply follows en.
  assign tick = en && !clear && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// Parallel-to-serial transmitter. A word accepted over the valid/ready
// handshake is sent on sout as: start bit (1), WIDTH data bits MSB first,
// stop bit (0). Each bit is held for BIT_CYCLES clocks. The line idles low.
//
// Handshake: a word transfers on a rising edge where data_valid and
// data_ready are both high and reset is low. data_ready is high only in
// IDLE; data_valid in any other state is ignored, and data_in is only
// looked at on the transfer edge.
//
// Parameters:
//   WIDTH      - data bits per frame (>= 1)
//   BIT_CYCLES - clocks per bit on sout (>= 1)
//
// Ports:
//   clk        in  clock, rising edge
//   reset      in  synchronous active-high reset
//   data_in    in  [WIDTH-1:0] word to send
//   data_valid in  producer has a word
//   data_ready out block can accept a word (registered)
//   sout       out serial line (registered)
//   busy       out frame in progress: START, DATA or STOP (registered)
//   done       out one-cycle pulse in the first IDLE cycle after STOP
//   dbg_state  out [1:0] current FSM state (tx_state_t encoding)
// -----------------------------------------------------------------------------
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Index only ever holds 0..WIDTH-1; the last bit is detected by compare,
  // never by overflow, so a power-of-two WIDTH needs no extra bit.
  localparam int IDXW = clog2_min1(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  tx_state_t        state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [IDXW-1:0]  idx, idx_n;

  logic timer_clear;
  logic timer_en;
  logic tick;

  logic sout_n;
  logic busy_n;
  logic ready_n;
  logic done_n;

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clear),
    .en   (timer_en),
    .tick (tick)
  );

  // ---------------------------------------------------------------------------
  // Next-state, datapath and next-output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    idx_n       = idx;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state)
      S_IDLE: begin
        // Hold the timer at zero so the start bit gets a full period.
        timer_clear = 1'b1;
        if (data_valid && data_ready) begin
          shreg_n = data_in;
          idx_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        timer_en = 1'b1;
        if (tick) begin
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        timer_en = 1'b1;
        if (tick) begin
          shreg_n = shreg << 1;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = S_STOP;
          end else begin
            idx_n = idx + IDXW'(1);
          end
        end
      end
      S_STOP: begin
        timer_en = 1'b1;
        if (tick) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered alongside it,
    // so they line up with the state they describe and have no path from
    // the inputs to the pins.
    case (state_n)
      S_START: sout_n = START_LVL;
      S_DATA:  sout_n = shreg_n[WIDTH-1];
      S_STOP:  sout_n = STOP_LVL;
      default: sout_n = IDLE_LVL;
    endcase

    busy_n  = (state_n != S_IDLE);
    ready_n = (state_n == S_IDLE);
    done_n  = (state == S_STOP) && (state_n == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shreg      <= '0;
      idx        <= '0;
      sout       <= IDLE_LVL;
      busy       <= 1'b0;
      done       <= 1'b0;
      // Held low through reset so nothing is accepted until the first
      // cycle after reset is released.
      data_ready <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      idx        <= idx_n;
      sout       <= sout_n;
      busy       <= busy_n;
      done       <= done_n;
      data_ready <= ready_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//
// Bench for serial_tx. Two instances share one clock:
//   u_dut1 : WIDTH=8, BIT_CYCLES=1 (table vectors and corner sequences)
//   u_dut3 : WIDTH=8, BIT_CYCLES=3 (stretched bit periods)
// Inputs are driven just after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_serial_tx;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst1, dv1, rdy1, sout1, busy1, done1;
  logic [W-1:0] din1;
  logic [1:0]   dbg1;

  logic         rst3, dv3, rdy3, sout3, busy3, done3;
  logic [W-1:0] din3;
  logic [1:0]   dbg3;

  serial_tx #(.WIDTH(W), .BIT_CYCLES(1)) u_dut1 (
    .clk       (clk),
    .reset     (rst1),
    .data_in   (din1),
    .data_valid(dv1),
    .data_ready(rdy1),
    .sout      (sout1),
    .busy      (busy1),
    .done      (done1),
    .dbg_state (dbg1)
  );

  serial_tx #(.WIDTH(W), .BIT_CYCLES(3)) u_dut3 (
    .clk       (clk),
    .reset     (rst3),
    .data_in   (din3),
    .data_valid(dv3),
    .data_ready(rdy3),
    .sout      (sout3),
    .busy      (busy3),
    .done      (done3),
    .dbg_state (dbg3)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_err    = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: word, expected 10-bit line image (leftmost bit first on the
  // wire), and an optional mid-frame word that must be ignored.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] data;
    logic [9:0]   frame;
    logic         poke;
    logic [W-1:0] poke_data;
  } vec_t;

  vec_t vecs[6];

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic wait_ready1();
    int n = 0;
    while (rdy1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready1_timeout", rdy1, 1);
  endtask

  task automatic run_frame1(input logic [W-1:0] data, input logic [9:0] frame,
                            input logic poke, input logic [W-1:0] poke_data);
    wait_ready1();
    din1 = data;
    dv1  = 1'b1;
    @(posedge clk);
    #1;
    dv1  = 1'b0;
    din1 = ~data;
    for (int i = 0; i < 10; i++) exp_q.push_back(frame[9-i]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frame_sout", sout1, exp_q.pop_front());
      check("frame_busy", busy1, 1);
      check("frame_done_low", done1, 0);
      check("frame_ready_low", rdy1, 0);
      if (i == 0) check("frame_state_start", dbg1, 2'd1);
      if (poke && i == 4) begin
        din1 = poke_data;
        dv1  = 1'b1;
        @(posedge clk);
        #1;
        dv1  = 1'b0;
      end
    end
    @(negedge clk);
    check("end_done", done1, 1);
    check("end_ready", rdy1, 1);
    check("end_busy", busy1, 0);
    check("end_sout", sout1, 0);
    if (poke) begin
      @(negedge clk);
      check("poke_no_frame_busy", busy1, 0);
      check("poke_no_frame_sout", sout1, 0);
      check("poke_done_cleared", done1, 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0, 8'h00};
    vecs[1] = '{8'h00, 10'b1000000000, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 10'b1111111110, 1'b0, 8'h00};
    vecs[3] = '{8'h3C, 10'b1001111000, 1'b1, 8'hFF};
    vecs[4] = '{8'h81, 10'b1100000010, 1'b0, 8'h00};
    vecs[5] = '{8'h5A, 10'b1010110100, 1'b1, 8'h00};

    rst1 = 1'b1; dv1 = 1'b0; din1 = '0;
    rst3 = 1'b1; dv3 = 1'b0; din3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sout1", sout1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_ready1", rdy1, 0);
    check("rst_state1", dbg1, 2'd0);
    check("rst_sout3", sout3, 0);
    check("rst_ready3", rdy3, 0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    check("ready_still_low", rdy1, 0);
    @(negedge clk);
    check("ready_rises1", rdy1, 1);
    check("ready_rises3", rdy3, 1);
    check("idle_sout1", sout1, 0);

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      run_frame1(vecs[v].data, vecs[v].frame, vecs[v].poke, vecs[v].poke_data);
    end

    // Back-to-back: data_valid held high, 8'hFF then 8'h00
    din1 = 8'hFF;
    dv1  = 1'b1;
    @(posedge clk);
    #1;
    din1 = 8'h00;
    for (int i = 0; i < 10; i++) exp_q.push_back(i < 9 ? 1'b1 : 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b2b_f1_sout", sout1, exp_q.pop_front());
      check("b2b_f1_busy", busy1, 1);
    end
    @(negedge clk);
    check("b2b_gap_done", done1, 1);
    check("b2b_gap_ready", rdy1, 1);
    check("b2b_gap_sout", sout1, 0);
    check("b2b_gap_busy", busy1, 0);
    @(posedge clk);
    #1;
    dv1 = 1'b0;
    for (int i = 0; i < 10; i++) exp_q.push_back(i == 0 ? 1'b1 : 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("b2b_f2_sout", sout1, exp_q.pop_front());
      check("b2b_f2_busy", busy1, 1);
    end
    @(negedge clk);
    check("b2b_f2_done", done1, 1);

    // BIT_CYCLES=3, 8'h80: 6 high, 24 low, busy for 30
    din3 = 8'h80;
    dv3  = 1'b1;
    @(posedge clk);
    #1;
    dv3 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("bc3_sout", sout3, (i < 6) ? 1 : 0);
      check("bc3_busy", busy3, 1);
      check("bc3_done_low", done3, 0);
    end
    @(negedge clk);
    check("bc3_done", done3, 1);
    check("bc3_busy_end", busy3, 0);
    check("bc3_ready_end", rdy3, 1);

    // Reset during the 4th data bit of 8'hC3
    wait_ready1();
    din1 = 8'hC3;
    dv1  = 1'b1;
    @(posedge clk);
    #1;
    dv1 = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(i < 3 ? 1'b1 : 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_pre_sout", sout1, exp_q.pop_front());
    end
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(negedge clk);
    check("abort_sout", sout1, 0);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_ready_low", rdy1, 0);
    @(negedge clk);
    check("abort_ready_up", rdy1, 1);
    check("abort_no_done", done1, 0);
    check("abort_sout_idle", sout1, 0);
    run_frame1(8'h5A, 10'b1010110100, 1'b0, 8'h00);

    // reset and data_valid together: no frame
    rst1 = 1'b1;
    dv1  = 1'b1;
    din1 = 8'hFF;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    dv1  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstvalid_sout", sout1, 0);
      check("rstvalid_busy", busy1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
